// File: rtl/quicksort_ctrl_if.sv
// Handshake between the quicksort sequencer (master) and its Lomuto partition unit (slave).
// Carries the range and working array out, and the partitioned array and pivot back.
interface quicksort_ctrl_if #(
  parameter int unsigned ARR_WIDTH = 4
) ();
  logic                   part_start;
  logic [3:0]             part_lo_ind;
  logic [3:0]             part_hi_ind;
  logic [ARR_WIDTH*4-1:0] part_array_in;
  logic [ARR_WIDTH*4-1:0] part_array_out;
  logic                   part_ready;
  logic [3:0]             part_pivot_ind;

  modport master (
    output part_start, part_lo_ind, part_hi_ind, part_array_in,
    input  part_array_out, part_ready, part_pivot_ind
  );

  modport slave (
    input  part_start, part_lo_ind, part_hi_ind, part_array_in,
    output part_array_out, part_ready, part_pivot_ind
  );
endinterface

// File: rtl/quicksort_ctrl.sv
// Iterative quicksort sequencer: holds the working array and a LIFO of pending (lo, hi)
// ranges, launching one partition per popped range and pushing the non-trivial halves.
module quicksort_ctrl #(
  parameter int unsigned ARR_WIDTH   = 4,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ARR_WIDTH*4-1:0] array_in,
  output logic [ARR_WIDTH*4-1:0] array_out,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  quicksort_ctrl_if.master       part_bus
);
  localparam int unsigned SpW      = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned WdW      = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LastIdx  = 4'(ARR_WIDTH - 1);
  localparam bit          HasRange = ARR_WIDTH > 1;

  typedef enum logic [2:0] {
    StIdle, StPop, StLaunch, StWaitPart, StPushL, StPushR, StDone
  } state_e;

  typedef struct packed {
    logic [3:0] lo;
    logic [3:0] hi;
  } range_t;

  state_e                 state_q, state_d;
  logic [ARR_WIDTH*4-1:0] array_q;
  logic [3:0]             lo_q, hi_q, pivot_q;
  logic [SpW-1:0]         sp_q, sp_m1;
  logic [WdW-1:0]         wd_q;
  logic                   error_q;
  range_t                 stack_q [STACK_DEPTH];

  logic                   push_en;
  logic [IdxW-1:0]        push_idx;
  range_t                 push_data;
  range_t                 top;
  logic                   stack_full, push_l_want, push_r_want, timeout_hit;

  // 5-bit compares so pivot=0 cannot wrap below lo.
  assign push_l_want = {1'b0, pivot_q} > ({1'b0, lo_q} + 5'd1);
  assign push_r_want = ({1'b0, pivot_q} + 5'd1) < {1'b0, hi_q};
  assign stack_full  = sp_q == SpW'(STACK_DEPTH);
  assign timeout_hit = wd_q == WdW'(TIMEOUT - 1);
  assign sp_m1       = sp_q - 1'b1;
  assign top         = stack_q[sp_m1[IdxW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (start) state_d = StPop;
      StPop:      state_d = (sp_q == '0) ? StDone : StLaunch;
      StLaunch:   state_d = StWaitPart;
      StWaitPart: begin
        if (part_bus.part_ready) state_d = StPushL;
        else if (timeout_hit)    state_d = StDone;
      end
      StPushL:    state_d = (push_l_want && stack_full) ? StDone : StPushR;
      StPushR:    state_d = (push_r_want && stack_full) ? StDone : StPop;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    busy                   = state_q != StIdle;
    done                   = state_q == StDone;
    error                  = error_q;
    array_out              = array_q;
    part_bus.part_start    = state_q == StLaunch;
    part_bus.part_lo_ind   = lo_q;
    part_bus.part_hi_ind   = hi_q;
    part_bus.part_array_in = array_q;
  end

  // An accepted start always refills from slot 0, whatever sp was left at.
  always_comb begin
    push_en   = 1'b0;
    push_idx  = sp_q[IdxW-1:0];
    push_data = '0;
    case (state_q)
      StIdle: if (start && HasRange) begin
        push_en      = 1'b1;
        push_idx     = '0;
        push_data.hi = LastIdx;
      end
      StPushL: if (push_l_want && !stack_full) begin
        push_en      = 1'b1;
        push_data.lo = lo_q;
        push_data.hi = pivot_q - 4'd1;
      end
      StPushR: if (push_r_want && !stack_full) begin
        push_en      = 1'b1;
        push_data.lo = pivot_q + 4'd1;
        push_data.hi = hi_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_en) stack_q[push_idx] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      array_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      pivot_q <= '0;
      sp_q    <= '0;
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (start) begin
          array_q <= array_in;
          error_q <= 1'b0;
          sp_q    <= SpW'(HasRange);
        end
        StPop: if (sp_q != '0) begin
          lo_q <= top.lo;
          hi_q <= top.hi;
          sp_q <= sp_m1;
        end
        StLaunch: wd_q <= '0;
        StWaitPart: begin
          if (part_bus.part_ready) begin
            array_q <= part_bus.part_array_out;
            pivot_q <= part_bus.part_pivot_ind;
          end else begin
            wd_q <= wd_q + 1'b1;
            if (timeout_hit) error_q <= 1'b1;
          end
        end
        StPushL: if (push_l_want) begin
          if (stack_full) error_q <= 1'b1;
          else            sp_q    <= sp_q + 1'b1;
        end
        StPushR: if (push_r_want) begin
          if (stack_full) error_q <= 1'b1;
          else            sp_q    <= sp_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_quicksort_ctrl.sv
// Bench for quicksort_ctrl: three instances (normal, tiny stack, short watchdog) each
// served by a behavioural Lomuto partition; results checked against a reference sort.
module tb_quicksort_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] arr;
    logic [3:0]  piv;
  } part_t;

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
    int          parts;
  } vec_t;

  quicksort_ctrl_if #(.ARR_WIDTH(4)) ifa ();
  quicksort_ctrl_if #(.ARR_WIDTH(8)) ifb ();
  quicksort_ctrl_if #(.ARR_WIDTH(4)) ifc ();

  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [15:0] in_a = '0, in_c = '0, out_a, out_c;
  logic [31:0] in_b = '0, out_b;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, err_a, err_b, err_c;

  quicksort_ctrl #(.ARR_WIDTH(4), .STACK_DEPTH(4), .TIMEOUT(64)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .array_in(in_a), .array_out(out_a),
    .busy(busy_a), .done(done_a), .error(err_a), .part_bus(ifa)
  );
  quicksort_ctrl #(.ARR_WIDTH(8), .STACK_DEPTH(1), .TIMEOUT(64)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .array_in(in_b), .array_out(out_b),
    .busy(busy_b), .done(done_b), .error(err_b), .part_bus(ifb)
  );
  quicksort_ctrl #(.ARR_WIDTH(4), .STACK_DEPTH(4), .TIMEOUT(8)) dut_c (
    .clock(clock), .reset(reset), .start(start_c), .array_in(in_c), .array_out(out_c),
    .busy(busy_c), .done(done_c), .error(err_c), .part_bus(ifc)
  );

  // Element i of an n-element bus lives at nibble (n-1-i), i.e. index 0 is the MSB nibble.
  function automatic part_t lomuto(input logic [63:0] v, input int n, input int lo, input int hi);
    logic [3:0] a [16];
    logic [3:0] p, tmp;
    int k;
    part_t r;
    for (int i = 0; i < 16; i++) a[i] = 4'd0;
    for (int i = 0; i < n; i++) a[i] = v[(n-1-i)*4 +: 4];
    p = a[hi];
    k = lo;
    for (int j = lo; j < hi; j++) begin
      if (a[j] < p) begin
        tmp = a[k]; a[k] = a[j]; a[j] = tmp;
        k++;
      end
    end
    tmp = a[k]; a[k] = a[hi]; a[hi] = tmp;
    r.arr = '0;
    for (int i = 0; i < n; i++) r.arr[(n-1-i)*4 +: 4] = a[i];
    r.piv = 4'(k);
    return r;
  endfunction

  // Reference quicksort over an explicit range stack with a capacity limit.
  function automatic void model_sort(input logic [63:0] v, input int n, input int depth,
                                     output logic [63:0] res, output bit err, output int parts);
    int los[$];
    int his[$];
    int lo, hi, piv;
    bit stop;
    part_t pr;
    err = 0; parts = 0; stop = 0;
    if (n > 1) begin los.push_back(0); his.push_back(n - 1); end
    while (los.size() > 0 && !stop) begin
      lo = los.pop_back();
      hi = his.pop_back();
      parts++;
      pr = lomuto(v, n, lo, hi);
      v = pr.arr;
      piv = int'(pr.piv);
      if (piv > lo + 1) begin
        if (los.size() == depth) begin err = 1; stop = 1; end
        else begin los.push_back(lo); his.push_back(piv - 1); end
      end
      if (!stop && piv + 1 < hi) begin
        if (los.size() == depth) begin err = 1; stop = 1; end
        else begin los.push_back(piv + 1); his.push_back(hi); end
      end
    end
    res = v;
  endfunction

  // Partition stubs: a and b answer three cycles after launch, c never answers.
  part_t       pr_a, pr_b;
  logic        rdy_a = 1'b0, rdy_b = 1'b0, pend_a = 1'b0, pend_b = 1'b0;
  logic [15:0] res_a = '0;
  logic [31:0] res_b = '0;
  logic [3:0]  piv_a = '0, piv_b = '0;
  int          dly_a = 0, dly_b = 0, pcnt_a = 0, pcnt_b = 0, pcnt_c = 0;

  assign pr_a = lomuto({48'd0, ifa.part_array_in}, 4, int'(ifa.part_lo_ind),
                       int'(ifa.part_hi_ind));
  assign pr_b = lomuto({32'd0, ifb.part_array_in}, 8, int'(ifb.part_lo_ind),
                       int'(ifb.part_hi_ind));

  always @(posedge clock) begin
    if (ifa.part_start) pcnt_a <= pcnt_a + 1;
    if (reset) begin
      rdy_a <= 1'b0; pend_a <= 1'b0;
    end else begin
      rdy_a <= 1'b0;
      if (ifa.part_start) begin
        res_a <= pr_a.arr[15:0]; piv_a <= pr_a.piv; pend_a <= 1'b1; dly_a <= 2;
      end else if (pend_a) begin
        if (dly_a == 0) begin rdy_a <= 1'b1; pend_a <= 1'b0; end
        else dly_a <= dly_a - 1;
      end
    end
  end

  always @(posedge clock) begin
    if (ifb.part_start) pcnt_b <= pcnt_b + 1;
    if (reset) begin
      rdy_b <= 1'b0; pend_b <= 1'b0;
    end else begin
      rdy_b <= 1'b0;
      if (ifb.part_start) begin
        res_b <= pr_b.arr[31:0]; piv_b <= pr_b.piv; pend_b <= 1'b1; dly_b <= 2;
      end else if (pend_b) begin
        if (dly_b == 0) begin rdy_b <= 1'b1; pend_b <= 1'b0; end
        else dly_b <= dly_b - 1;
      end
    end
  end

  always @(posedge clock) if (ifc.part_start) pcnt_c <= pcnt_c + 1;

  assign ifa.part_ready = rdy_a; assign ifa.part_array_out = res_a; assign ifa.part_pivot_ind = piv_a;
  assign ifb.part_ready = rdy_b; assign ifb.part_array_out = res_b; assign ifb.part_pivot_ind = piv_b;
  assign ifc.part_ready = 1'b0;  assign ifc.part_array_out = '0;    assign ifc.part_pivot_ind = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic s, input logic [31:0] v);
    case (d)
      0:       begin start_a = s; in_a = v[15:0]; end
      1:       begin start_b = s; in_b = v;       end
      default: begin start_c = s; in_c = v[15:0]; end
    endcase
  endtask

  function automatic logic done_of(input int d);
    case (d) 0: return done_a; 1: return done_b; default: return done_c; endcase
  endfunction
  function automatic logic busy_of(input int d);
    case (d) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction
  function automatic logic err_of(input int d);
    case (d) 0: return err_a; 1: return err_b; default: return err_c; endcase
  endfunction
  function automatic logic [31:0] arr_of(input int d);
    case (d) 0: return {16'd0, out_a}; 1: return out_b; default: return {16'd0, out_c}; endcase
  endfunction
  function automatic int pcnt_of(input int d);
    case (d) 0: return pcnt_a; 1: return pcnt_b; default: return pcnt_c; endcase
  endfunction

  task automatic wait_done(input int d, input string tag, output logic [31:0] dout, output bit err);
    bit seen;
    seen = 0; dout = '0; err = 0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      if (done_of(d)) begin seen = 1; dout = arr_of(d); err = err_of(d); end
      else @(negedge clock);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    @(negedge clock);
    check({tag, "_busy_fall"}, 64'(busy_of(d)), 64'd0);
    check({tag, "_done_once"}, 64'(done_of(d)), 64'd0);
  endtask

  task automatic run(input int d, input string tag, input logic [31:0] din,
                     output logic [31:0] dout, output bit err, output int parts);
    int snap;
    snap = pcnt_of(d);
    @(negedge clock); drive(d, 1'b1, din);
    @(negedge clock); drive(d, 1'b0, din);
    wait_done(d, tag, dout, err);
    parts = pcnt_of(d) - snap;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got stuck expected finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "simulation time bound expired");
  end

  initial begin
    vec_t        vecs [4];
    logic [31:0] dout, v;
    logic [63:0] mres;
    bit          err, merr, seen, stray;
    int          parts, mparts, snap;

    vecs[0] = '{din: 16'h3142, exp: 16'h1234, parts: 2};
    vecs[1] = '{din: 16'h1234, exp: 16'h1234, parts: 3};
    vecs[2] = '{din: 16'h2222, exp: 16'h2222, parts: 3};
    vecs[3] = '{din: 16'h4321, exp: 16'h1234, parts: 3};

    repeat (3) @(negedge clock);
    check("rst_busy",  64'(busy_a), 64'd0);
    check("rst_done",  64'(done_a), 64'd0);
    check("rst_error", 64'(err_a), 64'd0);
    check("rst_array", 64'(out_a), 64'd0);
    check("rst_pstart", 64'(ifa.part_start), 64'd0);
    check("rst_lo", 64'(ifa.part_lo_ind), 64'd0);
    check("rst_hi", 64'(ifa.part_hi_ind), 64'd0);
    check("rst_array_b", 64'(out_b), 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run(0, $sformatf("vec%0d", i), {16'd0, vecs[i].din}, dout, err, parts);
      check($sformatf("vec%0d_array", i), 64'(dout[15:0]), 64'(vecs[i].exp));
      check($sformatf("vec%0d_error", i), 64'(err), 64'd0);
      check($sformatf("vec%0d_parts", i), 64'(parts), 64'(vecs[i].parts));
    end

    for (int i = 0; i < 20; i++) begin
      v = {16'd0, 16'($urandom())};
      model_sort({32'd0, v}, 4, 4, mres, merr, mparts);
      run(0, $sformatf("rnd_a%0d", i), v, dout, err, parts);
      check($sformatf("rnd_a%0d_array", i), 64'(dout[15:0]), 64'(mres[15:0]));
      check($sformatf("rnd_a%0d_error", i), 64'(err), 64'(merr));
      check($sformatf("rnd_a%0d_parts", i), 64'(parts), 64'(mparts));
    end

    // Right half of the first split cannot fit beside the left half in a 1-deep stack.
    run(1, "ovf", 32'h81726354, dout, err, parts);
    check("ovf_error", 64'(err), 64'd1);
    check("ovf_array", 64'(dout), 64'h12346758);
    check("ovf_parts", 64'(parts), 64'd1);

    for (int i = 0; i < 6; i++) begin
      v = $urandom();
      model_sort({32'd0, v}, 8, 1, mres, merr, mparts);
      run(1, $sformatf("rnd_b%0d", i), v, dout, err, parts);
      check($sformatf("rnd_b%0d_array", i), 64'(dout), 64'(mres[31:0]));
      check($sformatf("rnd_b%0d_error", i), 64'(err), 64'(merr));
      check($sformatf("rnd_b%0d_parts", i), 64'(parts), 64'(mparts));
    end

    // Watchdog: partition never answers.
    @(negedge clock); drive(2, 1'b1, 32'h3142);
    @(negedge clock); drive(2, 1'b0, 32'h3142);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (ifc.part_start) seen = 1;
      else @(negedge clock);
    end
    check("to_launch_seen", 64'(seen), 64'd1);
    repeat (8) @(negedge clock);
    check("to_done_early", 64'(done_c), 64'd0);
    check("to_err_early", 64'(err_c), 64'd0);
    @(negedge clock);
    check("to_done", 64'(done_c), 64'd1);
    check("to_err", 64'(err_c), 64'd1);
    @(negedge clock);
    check("to_idle", 64'(busy_c), 64'd0);
    check("to_err_sticky", 64'(err_c), 64'd1);
    @(negedge clock); drive(2, 1'b1, 32'h1234);
    @(negedge clock); drive(2, 1'b0, 32'h1234);
    check("to_err_cleared", 64'(err_c), 64'd0);
    check("to_busy", 64'(busy_c), 64'd1);
    wait_done(2, "to2", dout, err);
    check("to2_err", 64'(err), 64'd1);

    // Reset while waiting on the partition.
    @(negedge clock); drive(0, 1'b1, 32'h3142);
    @(negedge clock); drive(0, 1'b0, 32'h3142);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (ifa.part_start) seen = 1;
      else @(negedge clock);
    end
    check("mid_launch_seen", 64'(seen), 64'd1);
    @(negedge clock);
    check("mid_busy_before", 64'(busy_a), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    snap = pcnt_a;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy_a || ifa.part_start) stray = 1;
      @(negedge clock);
    end
    check("mid_no_activity", 64'(stray), 64'd0);
    check("mid_no_launch", 64'(pcnt_a - snap), 64'd0);
    check("mid_err_clear", 64'(err_a), 64'd0);

    // A start raised mid-sort with a different array must not disturb the sort.
    snap = pcnt_a;
    @(negedge clock); drive(0, 1'b1, 32'h3142);
    @(negedge clock); drive(0, 1'b0, 32'h3142);
    @(negedge clock);
    @(negedge clock); drive(0, 1'b1, 32'hFFFF);
    check("ign_busy", 64'(busy_a), 64'd1);
    @(negedge clock); drive(0, 1'b0, 32'hFFFF);
    wait_done(0, "ign", dout, err);
    check("ign_array", 64'(dout[15:0]), 64'h1234);
    check("ign_error", 64'(err), 64'd0);
    check("ign_parts", 64'(pcnt_a - snap), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
